sub_serial_ctrl: RTL and testbench
==================================

Name: sub_serial_ctrl

Overview:
Byte-serial wide subtraction controller. Latches two WIDTH-bit operands, then sequences a single 8-bit ripple-borrow subtractor slice over NBYTES cycles, LSB byte first, chaining the borrow through a register. Results are returned through a valid/ready handshake. Used where a wide subtract is needed and area matters more than latency.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8
NBYTES, WIDTH/8, derived localparam; number of slice passes
CNT_W, $clog2(NBYTES) (minimum 1), derived localparam; width of the byte index

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start_valid  input  1  request valid
start_ready  output  1  controller can accept a request (high only in IDLE)
a  input  WIDTH  minuend, sampled on the start handshake
b  input  WIDTH  subtrahend, sampled on the start handshake
bin  input  1  borrow-in for byte 0, sampled on the start handshake
res_valid  output  1  result valid
res_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
borrow_out  output  1  borrow out of the MSB byte
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, start_ready=1, res_valid=0, busy=0, diff=0, borrow_out=0, byte index=0, borrow register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. When start_valid=1, latch a, b, and bin into the borrow register, clear the index, and go to RUN. While start_valid=0, stay in IDLE.
- RUN: each cycle, the slice computes byte[idx] = a_byte - b_byte - borrow_reg. Write the result into diff[8*idx +: 8], update borrow_reg with the slice borrow, then increment idx. After the pass with idx = NBYTES-1, set borrow_out = slice borrow and go to DONE. The RUN phase lasts exactly NBYTES cycles.
- DONE: res_valid=1. diff and borrow_out hold stable. When res_ready=1, go to IDLE on the next edge and drop res_valid. While res_ready=0, hold indefinitely.
- Latency: handshake at edge T; res_valid is high from edge T+NBYTES+1. With res_ready tied high, the next start_ready is at T+NBYTES+2.
- Slice arithmetic per bit: d = x^y^c; borrow = (~x&y) | (~(x^y)&c). This is the ripple chain across 8 bits.
- start_valid outside IDLE is ignored: no latch, no state effect. The requester must hold the request until start_ready.
- res_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE: abort immediately to the reset values. The partial result is discarded, and no res_valid pulse occurs.
- WIDTH=8: a single RUN cycle; the index stays 0.
- diff is not cleared at start. It is a shifting write target and is defined only when res_valid=1.

Optional Feature:
Macro SUB_SERIAL_FLAGS_EN.
- When defined, two extra outputs are added:
  - zero_flag (1 bit): high when diff == 0. It accumulates as an AND across byte passes, so no wide compare is needed.
  - ovf_flag (1 bit): signed overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]).
  - Both are valid with res_valid and reset to 0.
- When undefined, these ports and their logic are absent; everything else is unchanged.

Decomposition:
- Shared package sub_serial_pkg holds:
  - the state enum typedef {IDLE, RUN, DONE} (2-bit);
  - the SLICE_W=8 constant;
  - a function computing NBYTES from WIDTH.
- One sub-module is natural: sub8_slice. It is purely combinational: 8-bit a, 8-bit b, borrow-in in; 8-bit diff and borrow-out out; built as a ripple of 1-bit full-subtractor cells. The controller instantiates it once.

Test Plan:
- WIDTH=32: a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, borrow_out=0; res_valid rises exactly 5 cycles after the start handshake.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, borrow_out=1 (borrow ripples through all 4 byte passes). With SUB_SERIAL_FLAGS_EN: zero_flag=0, ovf_flag=0.
- a=0x12345600, b=0x00000000, bin=1 -> diff=0x123455FF, borrow_out=0 (byte 0 borrows, byte 1 absorbs it).
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid stays 1 and diff stays stable; start_ready=0; a start_valid pulse during this time is ignored; releasing res_ready gives start_ready=1 on the next cycle.
- Assert rst for 1 cycle during RUN (idx=2) -> outputs return to reset values immediately with no res_valid. A fresh request a=0x80000000, b=0x00000001 then gives diff=0x7FFFFFFF; with the macro defined, ovf_flag=1.
- WIDTH=8 build: a=0x10, b=0x20, bin=0 -> diff=0xF0, borrow_out=1; res_valid 2 cycles after the handshake.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the byte-serial subtract controller.
package sub_serial_pkg;
  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nbytes(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/sub_serial_ctrl_if.sv
// Request/result handshake bundle for sub_serial_ctrl.
// SUB_SERIAL_FLAGS_EN adds zero_flag / ovf_flag to the bundle.
interface sub_serial_ctrl_if #(parameter int WIDTH = 32);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;
`ifdef SUB_SERIAL_FLAGS_EN
  logic             zero_flag;
  logic             ovf_flag;

  modport master (output start_valid, a, b, bin, res_ready,
                  input  start_ready, res_valid, diff, borrow_out, busy, zero_flag, ovf_flag);
  modport slave  (input  start_valid, a, b, bin, res_ready,
                  output start_ready, res_valid, diff, borrow_out, busy, zero_flag, ovf_flag);
`else
  modport master (output start_valid, a, b, bin, res_ready,
                  input  start_ready, res_valid, diff, borrow_out, busy);
  modport slave  (input  start_valid, a, b, bin, res_ready,
                  output start_ready, res_valid, diff, borrow_out, busy);
`endif
endinterface

// File: rtl/sub_serial_ctrl_sub8_slice.sv
// Combinational 8-bit ripple-borrow subtractor built from 1-bit full-subtractor cells.
module sub8_slice
  import sub_serial_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] diff,
  output logic               bout
);
  logic [SLICE_W:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[SLICE_W];
endmodule

// File: rtl/sub_serial_ctrl.sv
// Byte-serial WIDTH-bit subtract controller: one 8-bit slice, LSB byte first.
// SUB_SERIAL_FLAGS_EN adds accumulated zero and signed-overflow flags.
module sub_serial_ctrl
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  sub_serial_ctrl_if.slave   bus
);
  localparam int NBYTES = calc_nbytes(WIDTH);
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             brw_q, start_ready_q, res_valid_q, busy_q, borrow_out_q;

  logic [SLICE_W-1:0] s_a, s_b, s_diff;
  logic               s_bout, last;

  assign s_a  = a_q[idx*SLICE_W +: SLICE_W];
  assign s_b  = b_q[idx*SLICE_W +: SLICE_W];
  assign last = (idx == LAST);

  sub8_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (brw_q),
    .diff (s_diff),
    .bout (s_bout)
  );

`ifdef SUB_SERIAL_FLAGS_EN
  logic zero_acc, zero_q, ovf_q;
  assign bus.zero_flag = zero_q;
  assign bus.ovf_flag  = ovf_q;
`endif

  // DONE spends one cycle raising res_valid before the handshake can complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      diff_q        <= '0;
      brw_q         <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      borrow_out_q  <= 1'b0;
`ifdef SUB_SERIAL_FLAGS_EN
      zero_acc      <= 1'b0;
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q           <= bus.a;
            b_q           <= bus.b;
            brw_q         <= bus.bin;
            idx           <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= RUN;
`ifdef SUB_SERIAL_FLAGS_EN
            zero_acc      <= 1'b1;
`endif
          end
        end
        RUN: begin
          diff_q[idx*SLICE_W +: SLICE_W] <= s_diff;
          brw_q <= s_bout;
`ifdef SUB_SERIAL_FLAGS_EN
          zero_acc <= zero_acc & (s_diff == '0);
`endif
          if (last) begin
            borrow_out_q <= s_bout;
            state        <= DONE;
`ifdef SUB_SERIAL_FLAGS_EN
            zero_q <= zero_acc & (s_diff == '0);
            ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ s_diff[SLICE_W-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
          end else if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.diff        = diff_q;
  assign bus.borrow_out  = borrow_out_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Scoreboard bench for sub_serial_ctrl: WIDTH=32 and WIDTH=8 instances side by side.
module tb_sub_serial_ctrl;
  typedef struct packed {
    logic [31:0] diff;
    logic        bo;
    logic        z;
    logic        v;
  } exp_t;

  logic clk, rst;
  exp_t q32[$];
  exp_t q8[$];
  int   checks   = 0;
  int   failures = 0;

  sub_serial_ctrl_if #(.WIDTH(32)) b32();
  sub_serial_ctrl_if #(.WIDTH(8))  b8();

  sub_serial_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  sub_serial_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // result monitors: pop on each accepted result
  always @(negedge clk) begin
    if (!rst && b32.res_valid && b32.res_ready) begin
      if (q32.size() == 0) chk("unexpected_res32", 1, 0);
      else begin
        exp_t e;
        e = q32.pop_front();
        chk("diff32", b32.diff, e.diff);
        chk("borrow32", {31'd0, b32.borrow_out}, {31'd0, e.bo});
`ifdef SUB_SERIAL_FLAGS_EN
        chk("zero32", {31'd0, b32.zero_flag}, {31'd0, e.z});
        chk("ovf32",  {31'd0, b32.ovf_flag},  {31'd0, e.v});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b8.res_valid && b8.res_ready) begin
      if (q8.size() == 0) chk("unexpected_res8", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("diff8", {24'd0, b8.diff}, e.diff);
        chk("borrow8", {31'd0, b8.borrow_out}, {31'd0, e.bo});
`ifdef SUB_SERIAL_FLAGS_EN
        chk("zero8", {31'd0, b8.zero_flag}, {31'd0, e.z});
        chk("ovf8",  {31'd0, b8.ovf_flag},  {31'd0, e.v});
`endif
      end
    end
  end

  task automatic req32(input logic [31:0] a, input logic [31:0] b, input logic bin, input exp_t e);
    int k;
    logic got;
    q32.push_back(e);
    @(negedge clk);
    chk("start_ready32", {31'd0, b32.start_ready}, 32'd1);
    b32.a = a; b32.b = b; b32.bin = bin; b32.start_valid = 1'b1;
    @(posedge clk); #1 b32.start_valid = 1'b0;
    k = 0; got = 1'b0;
    while (k < 50 && !got) begin
      @(posedge clk); k++;
      @(negedge clk); got = b32.res_valid;
    end
    chk("latency32", k, 5);
    if (b32.res_ready) begin
      @(negedge clk);
      chk("idle_after32", {30'd0, b32.start_ready, b32.res_valid}, 32'd2);
    end
  endtask

  task automatic req8(input logic [7:0] a, input logic [7:0] b, input logic bin, input exp_t e);
    int k;
    logic got;
    q8.push_back(e);
    @(negedge clk);
    chk("start_ready8", {31'd0, b8.start_ready}, 32'd1);
    b8.a = a; b8.b = b; b8.bin = bin; b8.start_valid = 1'b1;
    @(posedge clk); #1 b8.start_valid = 1'b0;
    k = 0; got = 1'b0;
    while (k < 50 && !got) begin
      @(posedge clk); k++;
      @(negedge clk); got = b8.res_valid;
    end
    chk("latency8", k, 2);
    @(negedge clk);
    chk("idle_after8", {30'd0, b8.start_ready, b8.res_valid}, 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    b32.start_valid = 1'b0; b32.a = '0; b32.b = '0; b32.bin = 1'b0; b32.res_ready = 1'b1;
    b8.start_valid  = 1'b0; b8.a  = '0; b8.b  = '0; b8.bin  = 1'b0; b8.res_ready  = 1'b1;
    @(negedge clk);
    chk("rst_ready32", {31'd0, b32.start_ready}, 32'd1);
    chk("rst_flags32", {29'd0, b32.res_valid, b32.busy, b32.borrow_out}, 32'd0);
    chk("rst_diff32", b32.diff, 32'd0);
    chk("rst_ready8", {31'd0, b8.start_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // directed vectors: diff, borrow_out, zero_flag, ovf_flag
    req32(32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b0});
    req32(32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    req32(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, '{32'h0000_0000, 1'b0, 1'b1, 1'b0});
    req32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h8000_0000, 1'b1, 1'b0, 1'b1});

    // backpressure in DONE, with an ignored start pulse
    b32.res_ready = 1'b0;
    req32(32'h1234_5600, 32'h0000_0000, 1'b1, '{32'h1234_55FF, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      b32.start_valid = (i == 3);
      b32.a = 32'hFFFF_FFFF; b32.b = 32'h0;
      @(negedge clk);
      chk("bp_valid", {31'd0, b32.res_valid}, 32'd1);
      chk("bp_diff", b32.diff, 32'h1234_55FF);
      chk("bp_ready", {31'd0, b32.start_ready}, 32'd0);
    end
    b32.start_valid = 1'b0;
    @(posedge clk); #1 b32.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", {31'd0, b32.start_ready}, 32'd1);

    // reset during RUN at idx=2
    @(negedge clk);
    b32.a = 32'hDEAD_BEEF; b32.b = 32'h0101_0101; b32.start_valid = 1'b1;
    @(posedge clk); #1 b32.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, b32.start_ready}, 32'd1);
    chk("abort_flags", {29'd0, b32.res_valid, b32.busy, b32.borrow_out}, 32'd0);
    chk("abort_diff", b32.diff, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    req32(32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1});

    // WIDTH=8 instance
    req8(8'h10, 8'h20, 1'b0, '{32'h0000_00F0, 1'b1, 1'b0, 1'b0});
    req8(8'h80, 8'h01, 1'b1, '{32'h0000_007E, 1'b0, 1'b0, 1'b1});
    req8(8'h33, 8'h33, 1'b0, '{32'h0000_0000, 1'b0, 1'b1, 1'b0});

    repeat (5) @(negedge clk);
    chk("q32_drained", q32.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
